// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART-to-APB command decoder.
package uart_apb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR    = 3'd1,
    ST_WDATA   = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_TX      = 3'd6
  } state_e;

  localparam logic [7:0] CMD_WRITE    = 8'h57;
  localparam logic [7:0] CMD_READ     = 8'h52;
  localparam logic [7:0] DEF_ACK_BYTE = 8'h4B;
  localparam logic [7:0] DEF_ERR_BYTE = 8'h45;

  localparam int ADDR_BYTES = 2;
  localparam int DATA_BYTES = 4;

endpackage

// File: rtl/uart_apb_resp_ser.sv
// Response serializer: holds up to four bytes and presents them MSB first.
// Handshake: a byte is transferred in a cycle where valid & ready are both 1;
// data stays stable while valid is high and ready is low.
module uart_apb_resp_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        multi,
  input  logic [31:0] word,
  output logic        valid,
  output logic [7:0]  data,
  input  logic        ready,
  output logic        done
);

  logic [31:0] word_q;
  logic [1:0]  left_q;
  logic        valid_q;

  // left_q counts bytes still queued behind the one being presented
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q  <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      word_q  <= word;
      left_q  <= multi ? 2'd3 : 2'd0;
      valid_q <= 1'b1;
    end else if (valid_q && ready) begin
      if (left_q == 2'd0) begin
        valid_q <= 1'b0;
      end else begin
        left_q <= left_q - 2'd1;
        word_q <= {word_q[23:0], 8'h00};
      end
    end
  end

  assign valid = valid_q;
  assign data  = word_q[31:24];
  assign done  = valid_q && ready && (left_q == 2'd0);

endmodule

// File: rtl/uart_apb_cmd.sv
// Decodes framed read/write commands from the UART byte stream, issues APB
// request pulses and returns ACK/ERR bytes or read data to the transmitter.
module uart_apb_cmd
  import uart_apb_pkg::*;
#(
  parameter int unsigned BYTE_TIMEOUT = 100_000,
  parameter int unsigned RD_TIMEOUT   = 1024,
  parameter logic [7:0]  ACK_BYTE     = DEF_ACK_BYTE,
  parameter logic [7:0]  ERR_BYTE     = DEF_ERR_BYTE
) (
  input  logic        iCLK,
  input  logic        iRESETn,
  input  logic        iRX_VALID,
  input  logic [7:0]  iRX_DATA,
  output logic        oTX_VALID,
  output logic [7:0]  oTX_DATA,
  input  logic        iTX_READY,
  output logic        oAPB_WRITE,
  output logic        oAPB_READ,
  output logic [15:0] oAPB_ADDR,
  output logic [31:0] oAPB_WDATA,
  input  logic        iAPB_RDATA_EN,
  input  logic [31:0] iAPB_RDATA,
  output logic        oOVERRUN,
  output state_e      dbg_state
);

  localparam int BT_W = (BYTE_TIMEOUT > 1) ? $clog2(BYTE_TIMEOUT) : 1;
  localparam int RT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
  localparam logic [RT_W-1:0] RT_LAST = RT_W'(RD_TIMEOUT - 1);

  state_e state, next_state;

  logic            is_write;
  logic [1:0]      byte_cnt;
  logic            byte_last;
  logic [15:0]     addr_sr;
  logic [31:0]     data_sr;
  logic [BT_W-1:0] byte_timer;
  logic [RT_W-1:0] rd_timer;
  logic [15:0]     apb_addr;
  logic [31:0]     apb_wdata;

  logic        ser_load;
  logic        ser_multi;
  logic [31:0] ser_word;
  logic        ser_done;

  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    ser_load   = 1'b0;
    ser_multi  = 1'b0;
    ser_word   = '0;
    byte_last  = (state == ST_ADDR) ? (byte_cnt == 2'(ADDR_BYTES - 1))
                                    : (byte_cnt == 2'(DATA_BYTES - 1));
    case (state)
      ST_IDLE: begin
        if (iRX_VALID && (iRX_DATA == CMD_WRITE || iRX_DATA == CMD_READ))
          next_state = ST_ADDR;
      end
      ST_ADDR, ST_WDATA: begin
        if (iRX_VALID) begin
          if (byte_last) begin
            if (state == ST_WDATA) next_state = ST_WR_REQ;
            else if (is_write)     next_state = ST_WDATA;
            else                   next_state = ST_RD_REQ;
          end
        end else if (byte_timer == BT_LAST) begin
          next_state = ST_IDLE;
        end
      end
      ST_WR_REQ: begin
        next_state = ST_TX;
        ser_load   = 1'b1;
        ser_word   = {ACK_BYTE, 24'h0};
      end
      ST_RD_REQ: begin
        next_state = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        // A strobe on the final timer cycle still wins over the timeout
        if (iAPB_RDATA_EN) begin
          next_state = ST_TX;
          ser_load   = 1'b1;
          ser_multi  = 1'b1;
          ser_word   = iAPB_RDATA;
        end else if (rd_timer == RT_LAST) begin
          next_state = ST_TX;
          ser_load   = 1'b1;
          ser_word   = {ERR_BYTE, 24'h0};
        end
      end
      ST_TX: begin
        if (ser_done) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Shift registers are kept apart from the APB outputs so the outputs only
  // change at the moment a request pulse is issued.
  always_ff @(posedge iCLK or negedge iRESETn) begin
    if (!iRESETn) begin
      is_write   <= 1'b0;
      byte_cnt   <= '0;
      addr_sr    <= '0;
      data_sr    <= '0;
      byte_timer <= '0;
      rd_timer   <= '0;
      apb_addr   <= '0;
      apb_wdata  <= '0;
    end else begin
      if (state == ST_IDLE) begin
        byte_cnt   <= '0;
        byte_timer <= '0;
        if (iRX_VALID && iRX_DATA == CMD_WRITE)     is_write <= 1'b1;
        else if (iRX_VALID && iRX_DATA == CMD_READ) is_write <= 1'b0;
      end else if (state == ST_ADDR || state == ST_WDATA) begin
        if (iRX_VALID) begin
          byte_timer <= '0;
          byte_cnt   <= byte_last ? 2'd0 : byte_cnt + 2'd1;
          if (state == ST_ADDR) begin
            addr_sr <= {addr_sr[7:0], iRX_DATA};
            if (byte_last && !is_write) apb_addr <= {addr_sr[7:0], iRX_DATA};
          end else begin
            data_sr <= {data_sr[23:0], iRX_DATA};
            if (byte_last) begin
              apb_addr  <= addr_sr;
              apb_wdata <= {data_sr[23:0], iRX_DATA};
            end
          end
        end else if (byte_timer != BT_LAST) begin
          byte_timer <= byte_timer + 1'b1;
        end
      end

      // Timer counts from the read pulse cycle itself, saturating
      if (state == ST_RD_REQ || state == ST_RD_WAIT) begin
        if (rd_timer != RT_LAST) rd_timer <= rd_timer + 1'b1;
      end else begin
        rd_timer <= '0;
      end
    end
  end

  uart_apb_resp_ser u_ser (
    .clk   (iCLK),
    .rst_n (iRESETn),
    .load  (ser_load),
    .multi (ser_multi),
    .word  (ser_word),
    .valid (oTX_VALID),
    .data  (oTX_DATA),
    .ready (iTX_READY),
    .done  (ser_done)
  );

  assign oAPB_WRITE = (state == ST_WR_REQ);
  assign oAPB_READ  = (state == ST_RD_REQ);
  assign oAPB_ADDR  = apb_addr;
  assign oAPB_WDATA = apb_wdata;
  assign oOVERRUN   = iRX_VALID && (state == ST_WR_REQ || state == ST_RD_REQ ||
                                    state == ST_RD_WAIT || state == ST_TX);
  assign dbg_state  = state;

endmodule
